l4_feature_streamer: RTL

L4_FEATURE_STREAMER -- requirements
Module: l4_feature_streamer

---
 rtl/lenet_pkg.sv | 14 +
 rtl/l4_feature_streamer_if.sv | 14 +
 rtl/stream_fifo.sv | 56 +++++
 rtl/l4_feature_streamer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet constants and L4 streamer FSM encoding
package lenet_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } stream_state_t;

  localparam int L4_BANK_WORDS  = 200;
  localparam int L4_TOTAL_WORDS = 2 * L4_BANK_WORDS;

endpackage

// File: rtl/l4_feature_streamer_if.sv
// rtl/l4_feature_streamer_if.sv - flattened feature stream towards the FC layer
interface l4_feature_streamer_if #(
  parameter int DATA_WIDTH = 12
) ();

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - synchronous FIFO with show-ahead head word and occupancy count
module stream_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l4_feature_streamer.sv
// rtl/l4_feature_streamer.sv - streams both L4 pooled-map banks as one flat word stream
// Optional L4_STREAM_RELU_EN: zero negative words at the FIFO output.
module l4_feature_streamer
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int MAP_WORDS     = 25,
  parameter int MAPS_PER_BANK = 8,
  parameter int RD_LAT        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            L4_output_read_addr,
  output logic                  L4_output_rd_en,
  input  logic [DATA_WIDTH-1:0] L4_output_read_data1,
  input  logic [DATA_WIDTH-1:0] L4_output_read_data2,
  l4_feature_streamer_if.master stream
);

  localparam int BANK_SIZE  = MAPS_PER_BANK * MAP_WORDS;
  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int IW         = $clog2(RD_LAT + 1);

  stream_state_t         state;
  logic [7:0]            addr;
  logic                  pass;
  logic [RD_LAT-1:0]     vld_pipe;
  logic [RD_LAT-1:0]     sel_pipe;
  logic [RD_LAT-1:0]     last_pipe;
  logic [IW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_wdata;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [DATA_WIDTH-1:0] head;
  logic                  credit_ok;
  logic                  rd_en;
  logic                  final_read;
  logic                  beat;

  // Every issued read owns a FIFO slot until its word is consumed.
  assign credit_ok  = !fifo_full && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign rd_en      = (state == S_READ) && credit_ok;
  assign final_read = rd_en && pass && (addr == 8'(BANK_SIZE - 1));
  assign beat       = stream.out_valid && stream.out_ready;

  assign L4_output_read_addr = addr;
  assign L4_output_rd_en     = rd_en;

  assign fifo_wdata = {last_pipe[RD_LAT-1],
                       sel_pipe[RD_LAT-1] ? L4_output_read_data2 : L4_output_read_data1};
  assign head       = fifo_rdata[DATA_WIDTH-1:0];

  assign stream.out_valid = !fifo_empty;
  assign stream.out_last  = !fifo_empty && fifo_rdata[DATA_WIDTH];
`ifdef L4_STREAM_RELU_EN
  assign stream.out_data  = (fifo_empty || head[DATA_WIDTH-1]) ? '0 : head;
`else
  assign stream.out_data  = fifo_empty ? '0 : head;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      addr  <= '0;
      pass  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            busy  <= 1'b1;
          end
        end
        S_READ: begin
          if (rd_en) begin
            if (addr == 8'(BANK_SIZE - 1)) begin
              addr <= '0;
              pass <= ~pass;
              if (pass) state <= S_DRAIN;
            end else begin
              addr <= addr + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (beat && stream.out_last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read tags travel alongside the memory latency so capture needs no address compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      sel_pipe  <= '0;
      last_pipe <= '0;
      inflight  <= '0;
    end else begin
      vld_pipe[0]  <= rd_en;
      sel_pipe[0]  <= pass;
      last_pipe[0] <= final_read;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        sel_pipe[i]  <= sel_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      case ({rd_en, vld_pipe[RD_LAT-1]})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[RD_LAT-1]),
    .push_data (fifo_wdata),
    .pop       (beat),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
